itag_flush_banks: RTL and testbench
===================================

ITAG_FLUSH_BANKS -- requirements
Module: itag_flush_banks

Interface
REQ-001 The block SHALL take parameter WAYS, default 2, meaning the number of tag ways (1..8).
REQ-002 The block SHALL take parameter LINE_ADDR_W, default 6, meaning the line-index width (2^LINE_ADDR_W lines per way).
REQ-003 The block SHALL take parameter TAG_W, default 20, meaning the stored tag width, excluding the valid bit.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port stage1_adv, input, 1 bit: perform a tag read this cycle.
REQ-007 The block SHALL have port stage1_line_addr, input, LINE_ADDR_W bits: read index.
REQ-008 The block SHALL have port stage2_line_addr, input, LINE_ADDR_W bits: compare/fill index.
REQ-009 The block SHALL have port stage2_tag, input, TAG_W bits: compare/fill tag.
REQ-010 The block SHALL have port update, input, 1 bit: fill request.
REQ-011 The block SHALL have port update_way, input, WAYS bits: one-hot fill way.
REQ-012 The block SHALL have port inval, input, 1 bit: invalidate all ways of one line.
REQ-013 The block SHALL have port inval_addr, input, LINE_ADDR_W bits: line to invalidate.
REQ-014 The block SHALL have port flush_all, input, 1 bit: invalidate the whole array.
REQ-015 The block SHALL have port busy, output, 1 bit: a flush sweep is in progress.
REQ-016 The block SHALL have port tag_hit, output, 1 bit: some way hit.
REQ-017 The block SHALL have port tag_hit_way, output, WAYS bits: per-way hit vector.
REQ-018 The block SHALL have port multi_hit, output, 1 bit: more than one way hit (error flag).

Function
REQ-019 Storage SHALL be WAYS x 2^LINE_ADDR_W entries of {valid, tag}, with no reset on the storage itself; valid bits are cleared only by writes.
REQ-020 Reads SHALL be synchronous with one-cycle latency: stage1_adv=1 at cycle N presents the entries at stage1_line_addr for compare in cycle N+1.
REQ-021 When the same index is written and read in the same cycle, the read SHALL return the pre-write contents (read-first).
REQ-022 hit_allowed SHALL be a register loaded each cycle with stage1_adv & ~busy.
REQ-023 tag_hit_way[i] SHALL be hit_allowed & valid[i] & (tag[i]==stage2_tag); tag_hit SHALL be the OR of tag_hit_way; multi_hit SHALL be 1 iff two or more tag_hit_way bits are set.
REQ-024 The FSM SHALL have two states. IDLE transitions to SWEEP on rst or flush_all. SWEEP transitions to IDLE after the counter writes index 2^LINE_ADDR_W-1.
REQ-025 In SWEEP, each cycle SHALL write {valid=0} to all ways at the counter index. The counter SHALL then increment; it starts at 0 on entry, so a sweep takes exactly 2^LINE_ADDR_W cycles.
REQ-026 busy SHALL equal 1 exactly while in SWEEP.
REQ-027 Write port priority SHALL be sweep > inval > update. In IDLE, inval SHALL clear valid in all ways at inval_addr. Otherwise, update SHALL write {1, stage2_tag} to the update_way ways at stage2_line_addr.
REQ-028 inval, update and flush_all asserted while busy SHALL be dropped with no effect. The ongoing sweep already covers them, and it is not restarted.
REQ-029 inval and update in the same IDLE cycle SHALL perform only the inval; the fill is lost.
REQ-030 update with update_way=0 SHALL write nothing.

Reset
REQ-031 While rst=1, the FSM SHALL be forced to SWEEP with counter=0, and hit_allowed, tag_hit, tag_hit_way and multi_hit SHALL be 0.
REQ-032 After rst deasserts, busy SHALL stay 1 for 2^LINE_ADDR_W cycles; rst asserted mid-sweep SHALL restart the sweep from index 0.

Verification
REQ-033 The bench SHALL cover: release reset, no traffic -> busy=1 for exactly 64 cycles, then 0; a read of any index -> tag_hit=0.
REQ-034 The bench SHALL cover: fill way1 idx 5 tag 0xABCDE, then read idx 5 with stage2_tag 0xABCDE -> tag_hit_way=2'b10, tag_hit=1, multi_hit=0, one cycle after stage1_adv.
REQ-035 The bench SHALL cover: fill idx 5 tag 0x12345 in way0 and way1 -> compare gives tag_hit_way=2'b11, multi_hit=1.
REQ-036 The bench SHALL cover: after fill of idx 5, inval idx 5 together with update idx 9 -> idx 5 misses and idx 9 also misses (fill dropped).
REQ-037 The bench SHALL cover: flush_all at cycle 0, then rst at cycle 10 -> busy remains 1 through cycle 10+64; all previously filled lines miss afterwards.
REQ-038 The bench SHALL cover: same-cycle read and fill of idx 7 -> the compare sees the old (invalid) entry and misses; a read on the next cycle hits.

Source files
------------

// File: rtl/itag_flush_banks.sv
// Instruction-cache tag array: WAYS banks of {valid, tag} with one-cycle read,
// stage-2 hit compare, per-line invalidate and a full-array flush sweep.
module itag_flush_banks #(
   parameter int WAYS        = 2,
   parameter int LINE_ADDR_W = 6,
   parameter int TAG_W       = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stage1_adv,
   input  logic [LINE_ADDR_W-1:0] stage1_line_addr,
   input  logic [LINE_ADDR_W-1:0] stage2_line_addr,
   input  logic [TAG_W-1:0]       stage2_tag,
   input  logic                   update,
   input  logic [WAYS-1:0]        update_way,
   input  logic                   inval,
   input  logic [LINE_ADDR_W-1:0] inval_addr,
   input  logic                   flush_all,
   output logic                   busy,
   output logic                   tag_hit,
   output logic [WAYS-1:0]        tag_hit_way,
   output logic                   multi_hit
);

   localparam int DEPTH = 1 << LINE_ADDR_W;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SWEEP = 1'b1;

   logic [0:0]             state_reg, state_next;
   logic [LINE_ADDR_W-1:0] cnt_reg, cnt_next;
   logic                   hit_allowed_reg;

   logic [WAYS-1:0]        wr_en;
   logic [LINE_ADDR_W-1:0] wr_addr;
   logic [TAG_W:0]         wr_data;
   logic [WAYS-1:0]        hit_way;

   assign busy = (state_reg == SWEEP);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (flush_all) begin
               state_next = SWEEP;
               cnt_next   = '0;
            end
         end
         SWEEP: begin
            cnt_next = cnt_reg + LINE_ADDR_W'(1);
            if (cnt_reg == '1)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Reset lands in SWEEP so the unreset storage is scrubbed before use.
      if (rst) begin
         state_next = SWEEP;
         cnt_next   = '0;
      end
   end

   always_ff @(posedge clk) begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      hit_allowed_reg <= rst ? 1'b0 : (stage1_adv & ~busy);
   end

   // Single shared write port: sweep beats inval beats fill.
   always_comb begin
      wr_en   = '0;
      wr_addr = cnt_reg;
      wr_data = '0;
      if (busy) begin
         wr_en = '1;
      end else if (!rst && inval) begin
         wr_en   = '1;
         wr_addr = inval_addr;
      end else if (!rst && update) begin
         wr_en   = update_way;
         wr_addr = stage2_line_addr;
         wr_data = {1'b1, stage2_tag};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_way
         logic [TAG_W:0] mem [DEPTH];
         logic [TAG_W:0] rd_reg;

         // Non-blocking write and read of the same entry give read-first.
         always_ff @(posedge clk) begin
            if (wr_en[gi])
               mem[wr_addr] <= wr_data;
            if (stage1_adv)
               rd_reg <= mem[stage1_line_addr];
         end

         assign hit_way[gi] = rd_reg[TAG_W] && (rd_reg[TAG_W-1:0] == stage2_tag);
      end
   endgenerate

   assign tag_hit_way = (hit_allowed_reg && !rst) ? hit_way : '0;
   assign tag_hit     = |tag_hit_way;
   assign multi_hit   = |(tag_hit_way & (tag_hit_way - WAYS'(1)));

endmodule

// File: tb/tb_itag_flush_banks.sv
// Scoreboard bench for itag_flush_banks: reads push expected hit vectors,
// an independent monitor pops and compares them in the compare cycle.
module tb_itag_flush_banks;

   localparam int WAYS = 2;
   localparam int LAW  = 6;
   localparam int TW   = 20;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            stage1_adv = 1'b0;
   logic [LAW-1:0]  stage1_line_addr = '0;
   logic [LAW-1:0]  stage2_line_addr = '0;
   logic [TW-1:0]   stage2_tag = '0;
   logic            update = 1'b0;
   logic [WAYS-1:0] update_way = '0;
   logic            inval = 1'b0;
   logic [LAW-1:0]  inval_addr = '0;
   logic            flush_all = 1'b0;
   logic            busy;
   logic            tag_hit;
   logic [WAYS-1:0] tag_hit_way;
   logic            multi_hit;

   itag_flush_banks #(.WAYS(WAYS), .LINE_ADDR_W(LAW), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .stage1_adv(stage1_adv),
      .stage1_line_addr(stage1_line_addr), .stage2_line_addr(stage2_line_addr),
      .stage2_tag(stage2_tag), .update(update), .update_way(update_way),
      .inval(inval), .inval_addr(inval_addr), .flush_all(flush_all),
      .busy(busy), .tag_hit(tag_hit), .tag_hit_way(tag_hit_way),
      .multi_hit(multi_hit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WAYS-1:0] way;
      int              id;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   rd_id = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: a read accepted at an edge is compared just after that edge.
   initial begin
      logic was_adv;
      exp_t e;
      forever begin
         @(posedge clk);
         was_adv = stage1_adv;
         #1;
         if (was_adv) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               $display("rd %0d: hit_way=%b hit=%b multi=%b (want way=%b)",
                        e.id, tag_hit_way, tag_hit, multi_hit, e.way);
               check($sformatf("rd%0d.way", e.id), 32'(tag_hit_way), 32'(e.way));
               check($sformatf("rd%0d.hit", e.id), 32'(tag_hit), 32'(|e.way));
               check($sformatf("rd%0d.multi", e.id), 32'(multi_hit),
                     32'($countones(e.way) > 1));
            end
         end
      end
   end

   task automatic clear_ctl();
      rst        = 1'b0;
      stage1_adv = 1'b0;
      update     = 1'b0;
      update_way = '0;
      inval      = 1'b0;
      flush_all  = 1'b0;
   endtask

   task automatic push_rd(input int idx, input logic [TW-1:0] tag, input logic [WAYS-1:0] exp_way);
      exp_t e;
      stage1_adv       = 1'b1;
      stage1_line_addr = LAW'(idx);
      stage2_line_addr = LAW'(idx);
      stage2_tag       = tag;
      e.way = exp_way;
      e.id  = rd_id++;
      sb_q.push_back(e);
   endtask

   task automatic rd(input int idx, input logic [TW-1:0] tag, input logic [WAYS-1:0] exp_way);
      @(negedge clk);
      clear_ctl();
      push_rd(idx, tag, exp_way);
   endtask

   task automatic fill(input logic [WAYS-1:0] w, input int idx, input logic [TW-1:0] tag);
      @(negedge clk);
      clear_ctl();
      update           = 1'b1;
      update_way       = w;
      stage2_line_addr = LAW'(idx);
      stage2_tag       = tag;
      $display("fill way=%b idx=%0d tag=%05h", w, idx, tag);
   endtask

   task automatic idle();
      @(negedge clk);
      clear_ctl();
   endtask

   // Runs cycles until busy drops; events are placed at chosen cycle numbers.
   task automatic sweep_run(input string name, input int flush_at, input int rst_at,
                            input int flush2_at, input int upd_at, input int rd_at,
                            input int exp_len);
      int n = 0;
      do begin
         @(negedge clk);
         clear_ctl();
         if (n == flush_at || n == flush2_at) flush_all = 1'b1;
         if (n == rst_at) rst = 1'b1;
         if (n == upd_at) begin
            update = 1'b1; update_way = 2'b01;
            stage2_line_addr = LAW'(30); stage2_tag = 20'h33333;
            inval = 1'b1; inval_addr = LAW'(7);
         end
         if (n == rd_at) push_rd(12, 20'h11111, 2'b00);
         @(posedge clk);
         #1;
         n++;
      end while (busy && n < 300);
      $display("sweep %s: busy cycles=%0d", name, n);
      check(name, 32'(n), 32'(exp_len));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held: outputs quiet, busy set, a read during reset misses.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rst = 1'b1;
         stage1_adv = 1'b0;
         if (i == 1) push_rd(5, 20'h0, 2'b00);
         @(posedge clk);
         #1;
         check($sformatf("rst%0d.busy", i), 32'(busy), 32'd1);
         check($sformatf("rst%0d.hit_way", i), 32'(tag_hit_way), 32'd0);
      end
      sweep_run("reset_sweep", -1, -1, -1, -1, -1, 64);

      rd(0, 20'h0, 2'b00);
      rd(5, 20'h0, 2'b00);
      rd(63, 20'h0, 2'b00);

      fill(2'b10, 5, 20'hABCDE);
      rd(5, 20'hABCDE, 2'b10);
      rd(5, 20'hABCDF, 2'b00);
      rd(4, 20'hABCDE, 2'b00);

      fill(2'b11, 5, 20'h12345);
      rd(5, 20'h12345, 2'b11);

      // inval idx 5 and fill idx 9 together: only the inval happens.
      @(negedge clk);
      clear_ctl();
      inval = 1'b1; inval_addr = LAW'(5);
      update = 1'b1; update_way = 2'b01;
      stage2_line_addr = LAW'(9); stage2_tag = 20'h55555;
      rd(5, 20'h12345, 2'b00);
      rd(9, 20'h55555, 2'b00);

      fill(2'b00, 10, 20'h00777);
      rd(10, 20'h00777, 2'b00);

      // Same-cycle read and fill of idx 7: read-first miss, then hit.
      @(negedge clk);
      clear_ctl();
      update = 1'b1; update_way = 2'b01;
      push_rd(7, 20'h0F0F0, 2'b00);
      rd(7, 20'h0F0F0, 2'b01);

      // Flush with a second flush, an update, an inval and a read while busy.
      fill(2'b01, 12, 20'h11111);
      rd(12, 20'h11111, 2'b01);
      idle();
      sweep_run("flush_sweep", 0, -1, 5, 6, 3, 65);
      rd(12, 20'h11111, 2'b00);
      rd(30, 20'h33333, 2'b00);
      rd(7, 20'h0F0F0, 2'b00);

      // Flush then reset mid-sweep restarts the sweep.
      fill(2'b01, 12, 20'h11111);
      fill(2'b10, 40, 20'h22222);
      rd(40, 20'h22222, 2'b10);
      rd(12, 20'h11111, 2'b01);
      idle();
      sweep_run("flush_rst_sweep", 0, 10, -1, -1, -1, 75);
      rd(12, 20'h11111, 2'b00);
      rd(40, 20'h22222, 2'b00);

      idle();
      idle();
      idle();
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
